// File: rtl/mp_add_pkg.sv
// Shared types and constants for the multi-precision add scheduler.
// The optional subtract mode (macro MP_ADD_SUB_EN) uses CARRY_INIT_SUB.
package mp_add_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Requester id width; keeps a 1-bit id even for a degenerate single requester.
  function automatic int id_width(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  localparam logic CARRY_INIT_ADD = 1'b0;
  localparam logic CARRY_INIT_SUB = 1'b1;

endpackage

// File: rtl/carry_skip_generic.sv
// N-bit carry-skip adder: 4-bit ripple blocks whose carry bypasses a block
// when every bit of that block propagates. N must be a power of 2, >= 16.
module carry_skip_generic #(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int BLK = 4;

  logic c_blk;
  logic c_rip;
  logic p_all;
  logic p_bit;

  always_comb begin
    // NOTE: every variable gets a value before any branch or loop reads it,
    // so this block stays purely combinational and never infers a latch.
    sum   = '0;
    c_blk = cin;
    c_rip = 1'b0;
    p_all = 1'b0;
    p_bit = 1'b0;
    for (int blk = 0; blk < N / BLK; blk++) begin
      c_rip = c_blk;
      p_all = 1'b1;
      for (int j = 0; j < BLK; j++) begin
        p_bit                 = a[blk*BLK+j] ^ b[blk*BLK+j];
        sum[blk*BLK+j]        = p_bit ^ c_rip;
        c_rip                 = (a[blk*BLK+j] & b[blk*BLK+j]) | (p_bit & c_rip);
        p_all                 = p_all & p_bit;
      end
      c_blk = p_all ? c_blk : c_rip;
    end
    cout = c_blk;
  end

endmodule

// File: rtl/mp_add_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request found scanning
// upward from ptr+1 with wrap; returns one-hot and encoded grant.
module rr_arbiter
  import mp_add_pkg::*;
#(
  parameter int  R    = 4,
  localparam int ID_W = id_width(R)
) (
  input  logic [R-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [R-1:0]    grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    // Scan farthest-first so the candidate nearest to ptr+1 is written last.
    for (int i = R; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % R]) begin
        grant                       = '0;
        grant[(int'(ptr) + i) % R]  = 1'b1;
        idx                         = ID_W'((int'(ptr) + i) % R);
      end
    end
  end

endmodule

// File: rtl/mp_add_scheduler.sv
// Shares one carry_skip_generic adder among R requesters streaming multi-word
// adds; define MP_ADD_SUB_EN to add the per-requester subtract input req_sub.
module mp_add_scheduler
  import mp_add_pkg::*;
#(
  parameter int  N    = 64,
  parameter int  R    = 4,
  localparam int ID_W = id_width(R)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [R-1:0]      req_valid,
  output logic [R-1:0]      req_ready,
  input  logic [R*N-1:0]    req_a,
  input  logic [R*N-1:0]    req_b,
  input  logic [R-1:0]      req_last,
`ifdef MP_ADD_SUB_EN
  input  logic [R-1:0]      req_sub,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_sum,
  output logic [ID_W-1:0]   out_id,
  output logic              out_last,
  output logic              out_cout
);

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_q;
  logic [R-1:0]    grant_oh_q;
  logic            carry_q;

  logic [R-1:0]    arb_grant;
  logic [ID_W-1:0] arb_idx;
  logic            arb_any;
  logic            init_carry;
  logic            room;
  logic            accept;
  logic [N-1:0]    add_a;
  logic [N-1:0]    add_b;
  logic [N-1:0]    add_sum;
  logic            add_cout;

  rr_arbiter #(.R(R)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // The output register can take a new word when empty or draining this cycle.
  assign room      = !out_valid || out_ready;
  assign req_ready = (state == BUSY && room) ? grant_oh_q : '0;
  assign accept    = (state == BUSY) && room && req_valid[grant_q];
  assign add_a     = req_a[grant_q*N +: N];

`ifdef MP_ADD_SUB_EN
  logic sub_q;

  assign add_b      = sub_q ? ~req_b[grant_q*N +: N] : req_b[grant_q*N +: N];
  assign init_carry = req_sub[arb_idx] ? CARRY_INIT_SUB : CARRY_INIT_ADD;

  always_ff @(posedge clk) begin
    if (rst)                         sub_q <= 1'b0;
    else if (state == IDLE && arb_any) sub_q <= req_sub[arb_idx];
  end
`else
  assign add_b      = req_b[grant_q*N +: N];
  assign init_carry = CARRY_INIT_ADD;
`endif

  carry_skip_generic #(.N(N)) u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= ID_W'(R - 1);
      grant_q    <= '0;
      grant_oh_q <= '0;
      carry_q    <= 1'b0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_id     <= '0;
      out_last   <= 1'b0;
      out_cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant_q    <= arb_idx;
            grant_oh_q <= arb_grant;
            rr_ptr     <= arb_idx;
            carry_q    <= init_carry;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (accept) begin
            carry_q <= add_cout;
            if (req_last[grant_q]) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A refill wins over a drain, giving one word per cycle when streaming.
      if (accept) begin
        out_valid <= 1'b1;
        out_sum   <= add_sum;
        out_id    <= grant_q;
        out_last  <= req_last[grant_q];
        out_cout  <= req_last[grant_q] ? add_cout : 1'b0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
